// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data memory.
// One fixed-latency access in flight at a time, with stalls for the loser.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   if_req/if_addr      IF read request (held until if_valid)
//   if_rdata/if_valid   IF read data (held) and one-cycle completion pulse
//   dm_req/dm_we/...    DM request, write enable, address, write data
//   dm_rdata/dm_valid   DM load data (held) and one-cycle completion pulse
//   mem_en/mem_we/...   registered memory strobe, write enable, addr, wdata
//   mem_rdata           memory read data, valid MEM_LATENCY cycles after mem_en
//   stall_if/stall_mem  pipeline freeze requests
//   busy                an access is in progress
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam int LAT_W = 4;
   localparam int STV_W = $clog2(STARVE_MAX + 2);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t            state_q;
   logic              owner_dm_q;
   logic              txn_we_q;
   logic [LAT_W-1:0]  lat_q;
   logic [STV_W-1:0]  starve_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_valid_q;
   logic              dm_valid_q;

   logic any_req;
   logic grant_if;

   assign any_req = if_req | dm_req;

   // DM has priority unless IF has waited out STARVE_MAX DM grants.
   assign grant_if = if_req &
                     (~dm_req | (starve_q == STV_MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_dm_q  <= 1'b0;
         txn_we_q    <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         // Strobes and pulses are single-cycle by default.
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (!if_req) begin
                  starve_q <= '0;
               end else if (grant_if) begin
                  starve_q <= '0;
               end else if (starve_q != STV_MAX) begin
                  starve_q <= starve_q + STV_W'(1);
               end

               if (any_req) begin
                  owner_dm_q <= ~grant_if;
                  txn_we_q   <= ~grant_if & dm_we;
                  // Memory strobe is raised here so it is
                  // visible during ISSUE straight from a flop.
                  mem_en_q   <= 1'b1;
                  mem_we_q   <= ~grant_if & dm_we;
                  mem_addr_q <= grant_if ? if_addr : dm_addr;
                  mem_wdata_q <= grant_if ? '0 : dm_wdata;
                  state_q    <= ISSUE;
               end
            end

            ISSUE: begin
               lat_q   <= LAT_LOAD;
               state_q <= WAIT;
            end

            WAIT: begin
               if (lat_q == '0) begin
                  if (!owner_dm_q) begin
                     if_rdata_q <= mem_rdata;
                  end else if (!txn_we_q) begin
                     dm_rdata_q <= mem_rdata;
                  end
                  if_valid_q <= ~owner_dm_q;
                  dm_valid_q <= owner_dm_q;
                  state_q    <= RESP;
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end

            RESP: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;

   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = dm_req & ~dm_valid_q;
   assign busy      = (state_q != IDLE);

   a_one_owner : assert property (
      @(posedge clk) disable iff (!reset)
      !(if_valid_q && dm_valid_q)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int MEMLAT = 2;
   localparam int SMAX   = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          stall_if;
   logic          stall_mem;
   logic          busy;

   int tests_run = 0;
   int fails = 0;

   logic [DW-1:0] phys [logic [AW-1:0]];
   logic [DW-1:0] refm [logic [AW-1:0]];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW),
      .MEM_LATENCY(MEMLAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .busy(busy)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // Memory responder: data is valid only in the cycle MEMLAT after
   // mem_en; every other cycle carries random junk.
   initial begin
      int rd_cnt;
      logic [DW-1:0] rd_data;
      logic hit;
      rd_cnt = 0;
      rd_data = '0;
      forever begin
         @(negedge clk);
         hit = 1'b0;
         if (!reset) begin
            rd_cnt = 0;
         end else if (mem_en) begin
            if (mem_we) begin
               phys[mem_addr] = mem_wdata;
            end else begin
               rd_data = phys.exists(mem_addr) ? phys[mem_addr]
                                               : init_word(mem_addr);
               rd_cnt = MEMLAT;
            end
         end else if (rd_cnt > 0) begin
            rd_cnt--;
            hit = (rd_cnt == 0);
         end
         mem_rdata = hit ? rd_data : $urandom;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      int en_seen;
      en_seen = 0;
      reset = 1'b0;
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({mem_en, mem_we, if_valid, dm_valid, busy} !== 5'b0) begin
         fails++;
         $display("FAIL reset.ctl got %b exp 00000",
                  {mem_en, mem_we, if_valid, dm_valid, busy});
      end
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (mem_en) en_seen++;
      end
      tests_run++;
      if (en_seen != 0) begin
         fails++;
         $display("FAIL reset.mem_en got %0d strobes exp 0", en_seen);
      end
      tests_run++;
      if ({busy, stall_if, stall_mem, if_valid, dm_valid} !== 5'b0) begin
         fails++;
         $display("FAIL reset.idle got %b exp 00000",
                  {busy, stall_if, stall_mem, if_valid, dm_valid});
      end
      tests_run++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
         fails++;
         $display("FAIL reset.data got %h %h %h %h exp 0",
                  if_rdata, dm_rdata, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_if_read();
      phys[32'h40] = 32'h8C08_0004;
      @(negedge clk);
      if_addr = 32'h40;
      if_req = 1'b1;
      #1;
      tests_run++;
      if (stall_if !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL if_read.c0 got stall=%b busy=%b exp 1 0",
                  stall_if, busy);
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (mem_en !== (c == 1)) begin
            fails++;
            $display("FAIL if_read.mem_en c=%0d got %b exp %b",
                     c, mem_en, c == 1);
         end
         if (c == 1) begin
            tests_run++;
            if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
               fails++;
               $display("FAIL if_read.addr got %h we=%b exp 40 0",
                        mem_addr, mem_we);
            end
         end
         tests_run++;
         if (if_valid !== (c == 4) || stall_if !== (c < 4)) begin
            fails++;
            $display("FAIL if_read.vs c=%0d got v=%b s=%b exp %b %b",
                     c, if_valid, stall_if, c == 4, c < 4);
         end
         tests_run++;
         if (busy !== (c <= 4)) begin
            fails++;
            $display("FAIL if_read.busy c=%0d got %b exp %b",
                     c, busy, c <= 4);
         end
         if (c == 4) begin
            tests_run++;
            if (if_rdata !== 32'h8C08_0004) begin
               fails++;
               $display("FAIL if_read.rdata got %h exp 8c080004", if_rdata);
            end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      if_addr = 32'h44;
      if_req = 1'b1;
      dm_addr = 32'h100;
      dm_we = 1'b0;
      dm_req = 1'b1;
      #1;
      tests_run++;
      if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin
         fails++;
         $display("FAIL simul.c0 got %b %b exp 1 1", stall_if, stall_mem);
      end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         tests_run++;
         if (mem_en !== (c == 1 || c == 6)) begin
            fails++;
            $display("FAIL simul.mem_en c=%0d got %b", c, mem_en);
         end
         if (c == 1 || c == 6) begin
            tests_run++;
            if (mem_addr !== ((c == 1) ? 32'h100 : 32'h44)) begin
               fails++;
               $display("FAIL simul.addr c=%0d got %h", c, mem_addr);
            end
         end
         tests_run++;
         if (dm_valid !== (c == 4) || if_valid !== (c == 9)) begin
            fails++;
            $display("FAIL simul.valid c=%0d got dm=%b if=%b",
                     c, dm_valid, if_valid);
         end
         tests_run++;
         if (stall_mem !== (c < 4) || stall_if !== (c < 9)) begin
            fails++;
            $display("FAIL simul.stall c=%0d got mem=%b if=%b",
                     c, stall_mem, stall_if);
         end
         if (c == 4) begin
            tests_run++;
            if (dm_rdata !== init_word(32'h100)) begin
               fails++;
               $display("FAIL simul.dm_rdata got %h exp %h",
                        dm_rdata, init_word(32'h100));
            end
            dm_req = 1'b0;
         end
         if (c == 9) begin
            tests_run++;
            if (if_rdata !== init_word(32'h44)) begin
               fails++;
               $display("FAIL simul.if_rdata got %h exp %h",
                        if_rdata, init_word(32'h44));
            end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_dm_write();
      int en_cnt;
      int we_cnt;
      en_cnt = 0;
      we_cnt = 0;
      @(negedge clk);
      dm_addr = 32'h200;
      dm_wdata = 32'hDEAD_BEEF;
      dm_we = 1'b1;
      dm_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (mem_we) we_cnt++;
         if (c == 1) begin
            tests_run++;
            if (!mem_en || !mem_we || mem_addr !== 32'h200 ||
                mem_wdata !== 32'hDEAD_BEEF) begin
               fails++;
               $display("FAIL dm_write.issue got en=%b we=%b %h %h",
                        mem_en, mem_we, mem_addr, mem_wdata);
            end
         end
         tests_run++;
         if (dm_valid !== (c == 4)) begin
            fails++;
            $display("FAIL dm_write.valid c=%0d got %b", c, dm_valid);
         end
         tests_run++;
         if (dm_rdata !== init_word(32'h100)) begin
            fails++;
            $display("FAIL dm_write.rdata c=%0d got %h exp %h",
                     c, dm_rdata, init_word(32'h100));
         end
         if (c == 4) begin
            dm_req = 1'b0;
            dm_we = 1'b0;
         end
      end
      tests_run++;
      if (en_cnt != 1 || we_cnt != 1) begin
         fails++;
         $display("FAIL dm_write.strobes got en=%0d we=%0d exp 1 1",
                  en_cnt, we_cnt);
      end
      tests_run++;
      if (phys[32'h200] !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL dm_write.mem got %h exp deadbeef", phys[32'h200]);
      end
   endtask

   task automatic test_starvation();
      logic got [6];
      logic exp_own [6];
      int ng;
      bit done;
      exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ng = 0;
      done = 0;
      @(negedge clk);
      if_addr = 32'h80;
      if_req = 1'b1;
      dm_addr = 32'h300;
      dm_we = 1'b0;
      dm_req = 1'b1;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         if (mem_en && ng < 6) begin
            got[ng] = (mem_addr == 32'h80);
            ng++;
         end
         if (if_valid) if_req = 1'b0;
         if (dm_valid && ng >= 6) dm_req = 1'b0;
         if (!if_req && !dm_req) done = 1;
      end
      tests_run++;
      if (ng != 6 || !done) begin
         fails++;
         $display("FAIL starve.count got %0d grants done=%0d exp 6 1",
                  ng, done);
         if_req = 1'b0;
         dm_req = 1'b0;
      end
      for (int i = 0; i < ng; i++) begin
         tests_run++;
         if (got[i] !== exp_own[i]) begin
            fails++;
            $display("FAIL starve.grant%0d got if=%b exp if=%b",
                     i, got[i], exp_own[i]);
         end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int dv_cnt;
      dv_cnt = 0;
      @(negedge clk);
      dm_addr = 32'h100;
      dm_we = 1'b0;
      dm_req = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if ({mem_en, mem_we, if_valid, dm_valid, busy} !== 5'b0 ||
          {if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
         fails++;
         $display("FAIL reset_mid.clear got %b %h %h %h %h",
                  {mem_en, mem_we, if_valid, dm_valid, busy},
                  if_rdata, dm_rdata, mem_addr, mem_wdata);
      end
      dm_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (dm_valid || mem_en) dv_cnt++;
      end
      tests_run++;
      if (dv_cnt != 0) begin
         fails++;
         $display("FAIL reset_mid.ghost got %0d activity cycles exp 0",
                  dv_cnt);
      end
      if_addr = 32'h48;
      if_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         tests_run++;
         if (if_valid !== (c == 4)) begin
            fails++;
            $display("FAIL reset_mid.if_valid c=%0d got %b", c, if_valid);
         end
         if (c == 4) begin
            tests_run++;
            if (if_rdata !== init_word(32'h48)) begin
               fails++;
               $display("FAIL reset_mid.rdata got %h exp %h",
                        if_rdata, init_word(32'h48));
            end
            if_req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int next_dec, en_c, val_c, starve;
      bit if_act, dm_act, own_dm, win_if;
      logic e_we, e_en, e_ifv, e_dmv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_rdata, if_hold, dm_hold;
      next_dec = 0; en_c = -1; val_c = -1; starve = 0;
      if_act = 0; dm_act = 0; own_dm = 0;
      e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      if_hold = '0; dm_hold = '0;
      phys.delete();
      refm.delete();
      if_req = 1'b0;
      dm_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         e_en  = (t == en_c);
         e_ifv = (t == val_c) && !own_dm;
         e_dmv = (t == val_c) && own_dm;
         if (e_ifv) if_hold = e_rdata;
         if (e_dmv && !e_we) dm_hold = e_rdata;
         tests_run++;
         if (mem_en !== e_en || mem_we !== (e_en && e_we)) begin
            fails++;
            $display("FAIL rand.strobe t=%0d got en=%b we=%b exp %b %b",
                     t, mem_en, mem_we, e_en, e_en && e_we);
         end
         if (e_en) begin
            tests_run++;
            if (mem_addr !== e_addr ||
                (e_we && mem_wdata !== e_wdata)) begin
               fails++;
               $display("FAIL rand.bus t=%0d got %h %h exp %h %h",
                        t, mem_addr, mem_wdata, e_addr, e_wdata);
            end
         end
         tests_run++;
         if (if_valid !== e_ifv || dm_valid !== e_dmv) begin
            fails++;
            $display("FAIL rand.valid t=%0d got if=%b dm=%b exp %b %b",
                     t, if_valid, dm_valid, e_ifv, e_dmv);
         end
         tests_run++;
         if (if_rdata !== if_hold || dm_rdata !== dm_hold) begin
            fails++;
            $display("FAIL rand.rdata t=%0d got %h %h exp %h %h",
                     t, if_rdata, dm_rdata, if_hold, dm_hold);
         end
         tests_run++;
         if (busy !== (t < next_dec)) begin
            fails++;
            $display("FAIL rand.busy t=%0d got %b exp %b",
                     t, busy, t < next_dec);
         end
         // Requesters: hold until valid, then maybe issue again.
         if (if_act && if_valid) if_act = 0;
         if (dm_act && dm_valid) dm_act = 0;
         if (!if_act) begin
            if_addr = $urandom;
            if ($urandom_range(0, 2) == 0) begin
               if_act = 1;
               if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
         end
         if (!dm_act) begin
            dm_addr = $urandom;
            dm_wdata = $urandom;
            dm_we = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
               dm_act = 1;
               dm_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
         end
         if_req = if_act;
         dm_req = dm_act;
         #1;
         tests_run++;
         if (stall_if !== (if_act && !e_ifv) ||
             stall_mem !== (dm_act && !e_dmv)) begin
            fails++;
            $display("FAIL rand.stall t=%0d got %b %b exp %b %b",
                     t, stall_if, stall_mem,
                     if_act && !e_ifv, dm_act && !e_dmv);
         end
         if (t == next_dec) begin
            if (if_act || dm_act) begin
               win_if = if_act && (!dm_act || starve == SMAX);
               if (!if_act || win_if) starve = 0;
               else if (starve < SMAX) starve++;
               own_dm = !win_if;
               e_addr = win_if ? if_addr : dm_addr;
               e_we = !win_if && dm_we;
               e_wdata = dm_wdata;
               if (e_we) refm[e_addr] = e_wdata;
               else e_rdata = refm.exists(e_addr) ? refm[e_addr]
                                                  : init_word(e_addr);
               en_c = t + 1;
               val_c = t + MEMLAT + 2;
               next_dec = t + MEMLAT + 3;
            end else begin
               starve = 0;
               next_dec = t + 1;
            end
         end
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (MEMLAT + 4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_simultaneous();
      test_dm_write();
      test_starvation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the instruction-fetch (IF) port and the data-memory (DM) port of the MIPS core in Main. Each access is a fixed-latency transaction with one request outstanding at a time. The block returns read data to the winning requester and drives stall signals that the pipeline control uses to freeze PC and the IF/ID and EX/MEM registers.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive DM grants allowed while IF is pending before IF is forced

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  IF read request, held high until if_valid
if_addr  in  ADDR_W  IF word address
if_rdata  out  DATA_W  instruction returned; held until next IF completion
if_valid  out  1  one-cycle IF completion pulse
dm_req  in  1  DM request, held high until dm_valid
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  DM address
dm_wdata  in  DATA_W  DM write data
dm_rdata  out  DATA_W  load data returned; held until next DM read completion
dm_valid  out  1  one-cycle DM completion pulse (reads and writes)
mem_en  out  1  memory access strobe, high exactly one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid MEMLAT cycles after mem_en
stall_if  out  1  if_req & ~if_valid (combinational)
stall_mem  out  1  dm_req & ~dm_valid (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE; mem_en, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; latency counter = 0; starve counter = 0. Applies immediately mid-transaction. The aborted access is never completed or reported.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: no request: stay. Any request: arbitrate, register the winner (owner, addr, we, wdata), go to ISSUE.
- Arbitration: DM wins by default.
  - Exception: IF wins if if_req=1 and starve counter == STARVE_MAX.
  - Starve counter: +1 on each DM grant while if_req=1 (saturates at STARVE_MAX); cleared on any IF grant or when if_req=0 in IDLE.
- ISSUE (1 cycle): mem_en=1 with mem_addr/mem_we/mem_wdata from registers. Load the latency counter with MEMLAT-1. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter==0, capture mem_rdata into the owner's rdata register (reads only; writes leave dm_rdata unchanged) and go to RESP.
  - MEMLAT=1 means WAIT lasts one cycle.
  - mem_en=0 throughout WAIT.
- RESP (1 cycle): assert the owner's valid pulse, go to IDLE. Requests are not sampled in RESP.
- Timing: request seen in cycle 0 gives mem_en in cycle 1, mem_rdata sampled at the end of cycle 1+MEMLAT, valid in cycle MEMLAT+2, IDLE in cycle MEMLAT+3.
  - Back-to-back throughput is one access per MEMLAT+3 cycles.
- Requests or inputs changing while not in IDLE are ignored. Only registered values drive memory.
- if_valid and dm_valid are never high together. if_valid and dm_valid are never high for two consecutive cycles for the same requester.
- Simultaneous if_req and dm_req in IDLE: resolved per the arbitration rules above. The loser stays stalled and is granted at the next IDLE if still requesting.
- Dropping a request before valid is a protocol violation by the requester. A granted transaction still completes and pulses valid.

Test Plan:
1. Reset low for 3 cycles, then high, no requests -> all outputs 0, busy=0, mem_en never asserted.
2. IF only, if_addr=0x00000040, memory returns 0x8C080004 (MEMLAT=2) -> mem_en at cycle 1 with mem_addr=0x40; if_valid in cycle 4 with if_rdata=0x8C080004; stall_if high in cycles 0-3, low in cycle 4.
3. IF and DM read asserted together, dm_addr=0x100 -> DM serviced first (dm_valid cycle 4), IF issued next (mem_en cycle 6, if_valid cycle 9).
4. DM write, dm_addr=0x200, dm_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF for exactly one cycle; dm_valid pulses; dm_rdata unchanged.
5. dm_req held continuously with if_req high, STARVE_MAX=4 -> exactly 4 DM grants, then one IF grant, then DM resumes.
6. Reset pulled low during WAIT of a DM read -> outputs clear immediately, no dm_valid pulse; after release, a new IF request completes normally in MEMLAT+2 cycles.
